// File: rtl/eth_gmii_tx_framer_pkg.sv
// Shared constants for the GMII TX framer: byte codes,
// CRC32 parameters, frame section lengths and FSM states.
package eth_gmii_tx_framer_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;

    localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    localparam int PREAMBLE_LEN = 7;
    localparam int FCS_LEN      = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_FCS  = 3'd4;
    localparam logic [2:0] ST_IFG  = 3'd5;

    // FCS is the inverted CRC register, least significant byte first
    function automatic logic [7:0] fcs_byte(
        input logic [31:0] crc,
        input logic [1:0]  idx
    );
        logic [31:0] f;
        f = ~crc;
        return 8'(f >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/eth_gmii_tx_framer_crc32.sv
// Combinational CRC32 (IEEE 802.3, reflected) update
// for one byte, data bits consumed LSB first.
module eth_crc32_d8
    import eth_gmii_tx_framer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  d_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    // Eight bit-serial steps, flattened into an XOR network
    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d_i[i]) begin
                c = (c >> 1) ^ CRC32_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
    end

    assign crc_o = c;

endmodule

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload pulled from
// the TX FIFO, CRC32 FCS and inter-frame gap.
module eth_gmii_tx_framer
    import eth_gmii_tx_framer_pkg::*;
#(
    parameter int PAYLOAD_LEN = 64,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_valid,
    input  logic        fifo_empty,
    input  logic [10:0] fifo_rdusedw,
    input  logic        fifo_rd_rdy,
    output logic        fifo_re,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [15:0] frame_cnt
);

    localparam int          IFG_W   = $clog2(IFG_CYCLES + 1);
    localparam logic [10:0] LEN     = 11'(PAYLOAD_LEN);
    localparam logic [10:0] LEN_M1  = 11'(PAYLOAD_LEN - 1);
    localparam logic [2:0]  PRE_END = 3'(PREAMBLE_LEN - 1);
    localparam logic [2:0]  FCS_END = 3'(FCS_LEN - 1);
    localparam logic [IFG_W-1:0] IFG_END = IFG_W'(IFG_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [10:0]      pay_q, pay_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;
    logic [10:0]      rd_left_q, rd_left_d;
    logic             rd_pend_q, rd_pend_d;
    logic [31:0]      crc_q, crc_d;
    logic [7:0]       txd_q, txd_d;
    logic             en_q, en_d;
    logic             er_q, er_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic [15:0]      fcnt_q, fcnt_d;

    logic [31:0] crc_nxt;
    logic        start;
    logic        rd_win;
    logic        underrun;

    eth_crc32_d8 u_crc (
        .crc_i (crc_q),
        .d_i   (fifo_dout),
        .crc_o (crc_nxt)
    );

    // Start gate and read scheduling; reads run two cycles
    // ahead of the byte they feed (FIFO latency + output reg)
    always_comb begin
        start = tx_enable & fifo_rd_rdy & ~fifo_empty
              & (fifo_rdusedw >= LEN);
        rd_win = ((state_q == ST_PRE) && (cnt_q == PRE_END))
               || (state_q == ST_SFD) || (state_q == ST_PAY);
        underrun = rd_pend_q & ~fifo_valid;
        fifo_re = rd_win & (rd_left_q != 11'd0) & ~underrun;
    end

    // Next-state and next-output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_d     = pay_q;
        ifg_d     = ifg_q;
        rd_left_d = fifo_re ? rd_left_q - 11'd1 : rd_left_q;
        rd_pend_d = fifo_re;
        crc_d     = crc_q;
        txd_d     = txd_q;
        en_d      = en_q;
        er_d      = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        fcnt_d    = fcnt_q;

        case (state_q)
            ST_IDLE: begin
                en_d  = 1'b0;
                txd_d = 8'h00;
                if (start) begin
                    state_d   = ST_PRE;
                    cnt_d     = 3'd0;
                    txd_d     = ETH_PREAMBLE;
                    en_d      = 1'b1;
                    crc_d     = CRC32_INIT;
                    rd_left_d = LEN;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_END) begin
                    state_d = ST_SFD;
                    txd_d   = ETH_SFD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_SFD, ST_PAY: begin
                if (underrun) begin
                    // Mark the frame bad for one cycle, drop the rest
                    state_d   = ST_IFG;
                    ifg_d     = '0;
                    txd_d     = 8'h00;
                    en_d      = 1'b1;
                    er_d      = 1'b1;
                    abort_d   = 1'b1;
                    rd_left_d = 11'd0;
                end else begin
                    if (rd_pend_q) begin
                        txd_d = fifo_dout;
                        crc_d = crc_nxt;
                    end
                    if (state_q == ST_SFD) begin
                        state_d = ST_PAY;
                        pay_d   = 11'd0;
                    end else if (pay_q == LEN_M1) begin
                        state_d = ST_FCS;
                        cnt_d   = 3'd0;
                        txd_d   = fcs_byte(crc_q, 2'd0);
                    end else begin
                        pay_d = pay_q + 11'd1;
                    end
                end
            end
            ST_FCS: begin
                if (cnt_q == FCS_END) begin
                    state_d = ST_IFG;
                    ifg_d   = '0;
                    txd_d   = 8'h00;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    txd_d = fcs_byte(crc_q, cnt_q[1:0] + 2'd1);
                end
            end
            ST_IFG: begin
                txd_d = 8'h00;
                en_d  = 1'b0;
                if (ifg_q == IFG_END) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 8'h00;
                en_d    = 1'b0;
            end
        endcase
    end

    // State, CRC and registered GMII outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            pay_q     <= 11'd0;
            ifg_q     <= '0;
            rd_left_q <= 11'd0;
            rd_pend_q <= 1'b0;
            crc_q     <= CRC32_INIT;
            txd_q     <= 8'h00;
            en_q      <= 1'b0;
            er_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            fcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_q     <= pay_d;
            ifg_q     <= ifg_d;
            rd_left_q <= rd_left_d;
            rd_pend_q <= rd_pend_d;
            crc_q     <= crc_d;
            txd_q     <= txd_d;
            en_q      <= en_d;
            er_q      <= er_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign gmii_txd    = txd_q;
    assign gmii_tx_en  = en_q;
    assign gmii_tx_er  = er_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_cnt   = fcnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Scoreboard bench for eth_gmii_tx_framer: FIFO model feeds
// the DUT, a monitor rebuilds frames and compares to a model.
module tb_eth_gmii_tx_framer;

    localparam int LEN = 9;
    localparam int IFG = 12;
    localparam int FLEN = 12 + LEN;
    localparam int K_GOOD  = 0;
    localparam int K_ABORT = 1;
    localparam int K_TRUNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_enable = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_valid = 1'b0;
    logic        fifo_empty;
    logic [10:0] fifo_rdusedw;
    logic        fifo_rd_rdy = 1'b0;
    logic        fifo_re;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic [15:0] frame_cnt;

    eth_gmii_tx_framer #(
        .PAYLOAD_LEN (LEN),
        .IFG_CYCLES  (IFG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_enable    (tx_enable),
        .fifo_dout    (fifo_dout),
        .fifo_valid   (fifo_valid),
        .fifo_empty   (fifo_empty),
        .fifo_rdusedw (fifo_rdusedw),
        .fifo_rd_rdy  (fifo_rd_rdy),
        .fifo_re      (fifo_re),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Expected-frame table (stimulus writes, monitor consumes)
    logic [7:0]  pay_mem [0:1023];
    int          pay_wr = 0;
    int          exp_off [0:63];
    int          exp_kind [0:63];
    bit          exp_gap [0:63];
    bit          exp_fixed [0:63];
    logic [31:0] exp_fcs [0:63];
    int          exp_abort_at [0:63];
    int          exp_wr = 0;
    int          exp_rd = 0;

    // FIFO model storage (stimulus writes, FIFO process reads)
    logic [7:0] wr_mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_total = 0;
    int         flush_gen = 0;
    int         flush_seen = 0;
    bit         kill_en = 1'b0;
    int         kill_at = 0;

    assign fifo_rdusedw = 11'(wr_ptr - rd_ptr);
    assign fifo_empty   = (wr_ptr == rd_ptr);

    function automatic void chk(input string nm, input longint act,
                                input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, req, req, $time);
        end
    endfunction

    function automatic logic [31:0] crc_tab(input logic [7:0] x);
        logic [31:0] c;
        c = {24'h0, x};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] fcs_ref(input int e);
        logic [31:0] c;
        if (exp_fixed[e]) return exp_fcs[e];
        c = 32'hFFFFFFFF;
        for (int i = 0; i < LEN; i++)
            c = crc_tab(c[7:0] ^ pay_mem[exp_off[e] + i]) ^ (c >> 8);
        return ~c;
    endfunction

    function automatic logic [7:0] exp_byte(input int e, input int i);
        logic [31:0] f;
        if (i < 7) return 8'h55;
        if (i == 7) return 8'hD5;
        if (i < 8 + LEN) return pay_mem[exp_off[e] + i - 8];
        f = fcs_ref(e);
        return 8'(f >> (8 * (i - 8 - LEN)));
    endfunction

    // Non-show-ahead FIFO: data and valid one cycle after fifo_re
    always @(posedge clk) begin
        if (flush_gen != flush_seen) begin
            rd_ptr     <= wr_ptr;
            flush_seen <= flush_gen;
        end else if (fifo_re) begin
            rd_total <= rd_total + 1;
            if (kill_en && rd_total == kill_at) begin
                fifo_valid <= 1'b0;
            end else if (rd_ptr < wr_ptr) begin
                fifo_dout  <= wr_mem[rd_ptr];
                fifo_valid <= 1'b1;
                rd_ptr     <= rd_ptr + 1;
            end else begin
                fifo_valid <= 1'b0;
            end
        end else begin
            fifo_valid <= 1'b0;
        end
    end

    // Monitor: assemble GMII frames and score them
    logic [7:0] cur [0:127];
    int cur_n = 0;
    int re_cnt = 0;
    int gap_cnt = 0;
    int good_cnt = 0;
    bit in_frame = 1'b0;

    always @(negedge clk) begin
        int e;
        int first_bad;
        if (rst) begin
            if (cur_n != 0) begin
                if (exp_rd < exp_wr) begin
                    chk("trunc_kind", K_TRUNC, exp_kind[exp_rd]);
                    exp_rd++;
                end else begin
                    chk("unexpected_trunc", 1, 0);
                end
            end
            cur_n = 0; re_cnt = 0; in_frame = 1'b0;
            gap_cnt = 0; good_cnt = 0;
        end else begin
            if (fifo_re) re_cnt++;
            if (gmii_tx_en && !in_frame) begin
                in_frame = 1'b1;
                if (exp_rd < exp_wr && exp_gap[exp_rd])
                    chk("ifg_gap", gap_cnt, IFG + 1);
            end
            if (gmii_tx_en && gmii_tx_er) begin
                if (exp_rd < exp_wr) begin
                    e = exp_rd;
                    exp_rd++;
                    chk("abort_kind", K_ABORT, exp_kind[e]);
                    chk("abort_pos", cur_n, 8 + exp_abort_at[e]);
                    first_bad = cur_n;
                    for (int i = 0; i < cur_n; i++)
                        if (first_bad == cur_n && cur[i] != exp_byte(e, i))
                            first_bad = i;
                    chk("abort_prefix", first_bad, cur_n);
                    chk("abort_pulse", frame_abort, 1);
                    chk("abort_no_done", frame_done, 0);
                    chk("abort_cnt", frame_cnt, good_cnt);
                end else begin
                    chk("unexpected_abort", 1, 0);
                end
                in_frame = 1'b0; cur_n = 0; re_cnt = 0; gap_cnt = 0;
            end else if (gmii_tx_en) begin
                if (cur_n < 128) cur[cur_n] = gmii_txd;
                cur_n++;
            end else begin
                if (in_frame) begin
                    if (exp_rd < exp_wr) begin
                        e = exp_rd;
                        exp_rd++;
                        good_cnt = (good_cnt + 1) & 16'hFFFF;
                        chk("frame_kind", K_GOOD, exp_kind[e]);
                        chk("frame_len", cur_n, FLEN);
                        first_bad = (cur_n < FLEN) ? cur_n : FLEN;
                        for (int i = 0; i < FLEN && i < cur_n; i++)
                            if (first_bad == FLEN && cur[i] != exp_byte(e, i))
                                first_bad = i;
                        chk("frame_bytes_ok_upto", first_bad, FLEN);
                        chk("frame_done", frame_done, 1);
                        chk("frame_no_abort", frame_abort, 0);
                        chk("frame_cnt", frame_cnt, good_cnt);
                        chk("fifo_re_count", re_cnt, LEN);
                    end else begin
                        chk("unexpected_frame", 1, 0);
                    end
                    in_frame = 1'b0; cur_n = 0; re_cnt = 0; gap_cnt = 0;
                end
                gap_cnt++;
            end
        end
    end

    task automatic add_exp(input int kind, input bit gap, input bit ascii,
                           input int abort_at, output int off);
        off = pay_wr;
        for (int i = 0; i < LEN; i++)
            pay_mem[off + i] = ascii ? 8'(8'h31 + i) : 8'($urandom_range(0, 255));
        pay_wr = pay_wr + LEN;
        exp_off[exp_wr]      = off;
        exp_kind[exp_wr]     = kind;
        exp_gap[exp_wr]      = gap;
        exp_fixed[exp_wr]    = ascii;
        exp_fcs[exp_wr]      = 32'hCBF43926;
        exp_abort_at[exp_wr] = abort_at;
        exp_wr++;
    endtask

    task automatic push_fifo(input int off, input int n);
        for (int i = 0; i < n; i++) begin
            wr_mem[wr_ptr] = pay_mem[off + i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        tx_enable = 1'b1;
        while ((exp_rd != exp_wr || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_in_budget", (c < budget) ? 1 : 0, 1);
    endtask

    initial begin
        int off;
        int off3;
        int c;
        bit seen;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_en", gmii_tx_en, 0);
        chk("rst_txd", gmii_txd, 0);
        chk("rst_tx_er", gmii_tx_er, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_re", fifo_re, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_done_abort", {frame_done, frame_abort}, 0);

        // Known vector: "123456789" -> FCS 26 39 F4 CB
        fifo_rd_rdy = 1'b1;
        tx_enable = 1'b1;
        add_exp(K_GOOD, 1'b0, 1'b1, 0, off);
        push_fifo(off, LEN);
        drain(400);

        // One byte short: no start until the last byte lands
        add_exp(K_GOOD, 1'b0, 1'b0, 0, off);
        push_fifo(off, LEN - 1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_re || gmii_tx_en) seen = 1'b1;
        end
        chk("no_start_short", seen, 0);
        push_fifo(off + LEN - 1, 1);
        @(posedge clk);
        #1;
        chk("start_latency_en", gmii_tx_en, 1);
        chk("start_latency_txd", gmii_txd, 8'h55);
        drain(400);

        // Three buffered frames back to back
        add_exp(K_GOOD, 1'b0, 1'b0, 0, off);
        add_exp(K_GOOD, 1'b1, 1'b0, 0, off3);
        add_exp(K_GOOD, 1'b1, 1'b0, 0, off3);
        push_fifo(off, 3 * LEN);
        drain(1000);

        // Underrun on payload byte 5
        kill_at = rd_total + 5;
        kill_en = 1'b1;
        add_exp(K_ABORT, 1'b0, 1'b0, 5, off);
        push_fifo(off, LEN);
        c = 0;
        while (exp_rd != exp_wr && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("abort_seen", (exp_rd == exp_wr) ? 1 : 0, 1);
        kill_en = 1'b0;
        flush_gen = flush_gen + 1;
        @(negedge clk);
        add_exp(K_GOOD, 1'b0, 1'b0, 0, off);
        push_fifo(off, LEN);
        drain(400);

        // Async reset in the middle of the payload
        add_exp(K_TRUNC, 1'b0, 1'b0, 0, off);
        push_fifo(off, LEN);
        c = 0;
        while (!gmii_tx_en && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("trunc_start", gmii_tx_en, 1);
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_en", gmii_tx_en, 0);
        chk("mid_rst_txd", gmii_txd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fifo_re", fifo_re, 0);
        chk("mid_rst_flags", {gmii_tx_er, frame_done, frame_abort}, 0);
        flush_gen = flush_gen + 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_frame_cnt", frame_cnt, 0);
        add_exp(K_GOOD, 1'b0, 1'b0, 0, off);
        push_fifo(off, LEN);
        drain(400);

        // Random trickle-fed frames with tx_enable toggling
        for (int f = 0; f < 5; f++) begin
            add_exp(K_GOOD, 1'b0, 1'b0, 0, off);
            for (int i = 0; i < LEN; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    tx_enable = 1'($urandom_range(0, 1));
                end
                push_fifo(off + i, 1);
            end
        end
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
